// File: rtl/arb_out_pkg.sv
// Shared types and helpers for the arb_out merge stage.
// Width helper for the binary source index.
package arb_out_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int src_nbits(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int p_num_reqs_dflt = 2;
  localparam int p_src_nbits = src_nbits(p_num_reqs_dflt);

endpackage

// File: rtl/arb_out_rr_core.sv
// Round-robin core: one-hot priority register plus
// replicated-chain variable-priority grant with lock override.
module arb_out_rr_core
  import arb_out_pkg::*;
#(
  parameter int p_num_reqs = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [p_num_reqs-1:0] req,
  input  logic                  en,
  input  logic                  lock_val,
  input  logic [p_num_reqs-1:0] lock_mask,
  output logic [p_num_reqs-1:0] grant
);

  localparam int N = p_num_reqs;

  logic [N-1:0]   pri;
  logic [2*N-1:0] req2;
  logic [2*N-1:0] pri2;
  logic [2*N-1:0] g2;
  logic [N-1:0]   rr_grant;
  logic           c;

  // Doubled chain lets the carry wrap from bit N-1 back to bit 0.
  always_comb begin
    req2 = {req, req};
    pri2 = {{N{1'b0}}, pri};
    g2   = '0;
    c    = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      g2[i] = req2[i] & (c | pri2[i]);
      c     = (c | pri2[i]) & ~req2[i];
    end
    rr_grant = g2[N-1:0] | g2[2*N-1:N];
  end

  assign grant = lock_val ? (req & lock_mask)
                          : rr_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pri <= N'(1);
    end else if (en) begin
      pri <= {grant[N-2:0], grant[N-1]};
    end
  end

endmodule

// File: rtl/arb_out_stage.sv
// Registered N-to-1 round-robin merge stage.
// Optional multi-beat locking: ARB_OUT_LOCK_EN.
module arb_out_stage
  import arb_out_pkg::*;
#(
  parameter int p_num_reqs  = 2,
  parameter int p_msg_nbits = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs-1:0]             in_val,
  output logic [p_num_reqs-1:0]             in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
`ifdef ARB_OUT_LOCK_EN
  input  logic [p_num_reqs-1:0]             in_last,
`endif
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_msg_nbits-1:0]            out_msg,
  output logic [src_nbits(p_num_reqs)-1:0]  out_src
);

  localparam int N  = p_num_reqs;
  localparam int W  = p_msg_nbits;
  localparam int SW = src_nbits(p_num_reqs);

  logic         can_accept;
  logic [N-1:0] grant;
  logic         xfer;
  logic         rot_en;
  logic         lock_val;
  logic [N-1:0] lock_mask;
  logic [W-1:0] msg_sel;
  logic [SW-1:0] src_sel;

  assign can_accept = !out_val || out_rdy;
  assign in_rdy = grant & {N{can_accept & reset}};
  assign xfer   = |(in_val & in_rdy);

  always_comb begin
    msg_sel = '0;
    src_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        msg_sel = msg_sel | in_msg[i*W +: W];
        src_sel = src_sel | SW'(i);
      end
    end
  end

`ifdef ARB_OUT_LOCK_EN
  logic last_sel;

  assign last_sel = |(grant & in_last);
  assign rot_en   = xfer & last_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_val  <= 1'b0;
      lock_mask <= '0;
    end else if (xfer) begin
      lock_val  <= !last_sel;
      lock_mask <= grant;
    end
  end
`else
  assign rot_en    = xfer;
  assign lock_val  = 1'b0;
  assign lock_mask = '0;
`endif

  arb_out_rr_core #(
    .p_num_reqs (N)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .req       (in_val),
    .en        (rot_en),
    .lock_val  (lock_val),
    .lock_mask (lock_mask),
    .grant     (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val <= 1'b0;
      out_msg <= '0;
      out_src <= '0;
    end else if (xfer) begin
      out_val <= 1'b1;
      out_msg <= msg_sel;
      out_src <= src_sel;
    end else if (out_val && out_rdy) begin
      out_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_out_stage.sv
// Directed bench for arb_out_stage, N=4, 32-bit messages.
// Lock scenario runs when ARB_OUT_LOCK_EN is defined.
module tb_arb_out_stage;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic [N-1:0]   in_val;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_msg;
  logic [N-1:0]   in_last;
  logic           out_val;
  logic           out_rdy;
  logic [W-1:0]   out_msg;
  logic [1:0]     out_src;

  int n_chk;
  int n_err;

  logic [W-1:0] m [N];

  arb_out_stage #(
    .p_num_reqs  (N),
    .p_msg_nbits (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
`ifdef ARB_OUT_LOCK_EN
    .in_last (in_last),
`endif
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_msgs();
    for (int i = 0; i < N; i++)
      in_msg[i*W +: W] = m[i];
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < N; i++)
      m[i] = 32'h1111_1111 * (i + 1);
    load_msgs();
    reset   = 1'b0;
    in_val  = '1;
    in_last = '1;
    out_rdy = 1'b1;
    #1;
    check("rst_in_rdy", 64'(in_rdy), 64'h0);
    step();
    check("rst_out_val", 64'(out_val), 64'h0);
    check("rst_out_msg", 64'(out_msg), 64'h0);
    check("rst_out_src", 64'(out_src), 64'h0);
    check("rst_in_rdy2", 64'(in_rdy), 64'h0);
    reset = 1'b1;
    #1;

    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_rdy%0d", k),
            64'(in_rdy), 64'(1 << (k % 4)));
      step();
      check($sformatf("rr_val%0d", k),
            64'(out_val), 64'h1);
      check($sformatf("rr_msg%0d", k),
            64'(out_msg), 64'(m[k % 4]));
      check($sformatf("rr_src%0d", k),
            64'(out_src), 64'(k % 4));
    end

    in_val = '0;
    #1;
    check("idle_rdy", 64'(in_rdy), 64'h0);
    step();
    check("drain_val", 64'(out_val), 64'h0);
    check("drain_src", 64'(out_src), 64'h0);

    m[2] = 32'hA5A5_A5A5;
    load_msgs();
    in_val  = 4'b0100;
    out_rdy = 1'b0;
    #1;
    check("bp_rdy0", 64'(in_rdy), 64'h4);
    step();
    check("bp_val", 64'(out_val), 64'h1);
    check("bp_msg", 64'(out_msg), 64'hA5A5_A5A5);
    check("bp_src", 64'(out_src), 64'h2);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("bp_rdy_hold%0d", k),
            64'(in_rdy), 64'h0);
      step();
      check($sformatf("bp_val_hold%0d", k),
            64'(out_val), 64'h1);
      check($sformatf("bp_msg_hold%0d", k),
            64'(out_msg), 64'hA5A5_A5A5);
    end

    in_val  = '0;
    out_rdy = 1'b1;
    step();
    check("bp_drain", 64'(out_val), 64'h0);

    in_val = 4'b1001;
    #1;
    check("wrap_rdy3", 64'(in_rdy), 64'h8);
    step();
    check("wrap_src3", 64'(out_src), 64'h3);
    check("wrap_rdy0", 64'(in_rdy), 64'h1);
    step();
    check("wrap_src0", 64'(out_src), 64'h0);
    check("wrap_msg0", 64'(out_msg), 64'(m[0]));

    in_val = 4'b0010;
    #1;
    check("refill_rdy", 64'(in_rdy), 64'h2);
    step();
    check("refill_val", 64'(out_val), 64'h1);
    check("refill_msg", 64'(out_msg), 64'(m[1]));
    check("refill_src", 64'(out_src), 64'h1);

    in_val  = 4'b1111;
    out_rdy = 1'b0;
    #1;
    check("pre_rst_rdy", 64'(in_rdy), 64'h0);
    reset = 1'b0;
    #1;
    check("arst_val", 64'(out_val), 64'h0);
    check("arst_src", 64'(out_src), 64'h0);
    check("arst_msg", 64'(out_msg), 64'h0);
    check("arst_rdy", 64'(in_rdy), 64'h0);
    step();
    reset   = 1'b1;
    out_rdy = 1'b1;
    #1;
    check("post_rst_rdy", 64'(in_rdy), 64'h1);
    step();
    check("post_rst_src", 64'(out_src), 64'h0);

`ifdef ARB_OUT_LOCK_EN
    in_val  = 4'b0011;
    in_last = 4'b1101;
    #1;
    check("lk_rdy_a", 64'(in_rdy), 64'h2);
    step();
    check("lk_src_a", 64'(out_src), 64'h1);
    check("lk_rdy_b", 64'(in_rdy), 64'h2);
    step();
    check("lk_src_b", 64'(out_src), 64'h1);
    in_last = 4'b1111;
    #1;
    check("lk_rdy_c", 64'(in_rdy), 64'h2);
    step();
    check("lk_src_c", 64'(out_src), 64'h1);
    check("lk_rel_rdy", 64'(in_rdy), 64'h1);
    step();
    check("lk_rel_src", 64'(out_src), 64'h0);
`endif

    in_val = '0;
    step();
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/arb_out_stage.md
# arb_out_stage

Registered output stage that sits directly downstream of the round-robin arbitration logic on a shared channel. It takes N val/rdy requester ports, picks one winner per cycle with round-robin priority, and latches the winner's message into a single-entry output register with its own val/rdy handshake. It is the standard N-to-1 merge point in front of a shared memory or network port.

## Interface
- p_num_reqs, 2: number of requester ports; legal range 2..16.
- p_msg_nbits, 32: message width per port.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; all state clears while low.
- in_val  input  p_num_reqs  per-port valid.
- in_rdy  output  p_num_reqs  per-port ready; at most one bit high per cycle.
- in_msg  input  p_num_reqs*p_msg_nbits  port i occupies bits [i*p_msg_nbits +: p_msg_nbits].
- in_last  input  p_num_reqs  last beat of a message; present only with ARB_OUT_LOCK_EN.
- out_val  output  1  output register holds a valid beat.
- out_rdy  input  1  consumer accepts the beat.
- out_msg  output  p_msg_nbits  registered message.
- out_src  output  max(1,clog2(p_num_reqs))  binary index of the port that produced out_msg.

## Operation
- can_accept = !out_val || out_rdy. The register accepts when empty or when draining in the same cycle.
- Arbitration requests = in_val. Grant is one-hot, using variable-priority selection with a one-hot priority vector, with wrap-around from bit N-1 to bit 0.
- in_rdy[i] = grant[i] && can_accept. in_rdy depends combinationally on in_val and out_rdy. in_rdy must not depend on in_msg.
- A transfer on port i occurs when in_val[i] && in_rdy[i]. On a transfer:
  - out_msg is loaded from port i.
  - out_src is set to i.
  - out_val is set to 1.
- If out_val && out_rdy and there is no input transfer, out_val is cleared to 0. out_msg and out_src hold their last values.
- Priority update: on a transfer from port i, priority becomes one-hot at bit (i+1) mod N, so the winner has lowest priority next. With no transfer, priority holds.
- When can_accept = 0, all in_rdy are 0 and priority does not change.
- When no in_val is asserted, in_rdy is all 0 and state holds.

## Timing
- Reset values:
  - out_val = 0, out_msg = 0, out_src = 0.
  - priority = one-hot bit 0.
  - lock state clear.
  - in_rdy = 0 for as long as reset is low.
- Latency: a beat accepted in cycle t is visible on out_val/out_msg in cycle t+1.
- Throughput: 1 beat/cycle sustained while out_rdy stays high.
- Backpressure: while out_val && !out_rdy, out_msg and out_src hold stable.
- Reset asserted mid-operation: the held beat is discarded and out_val drops immediately (asynchronously). After deassertion, arbitration restarts from port 0 priority.

## Configuration
- ARB_OUT_LOCK_EN defined: multi-beat message locking is compiled in.
  - The in_last port exists.
  - A transfer with in_last = 0 locks the arbiter to that port.
  - While locked, only that port may be granted, even if other ports request.
  - The lock releases on that port's transfer with in_last = 1.
  - Priority rotates only on the in_last = 1 transfer.
  - Reset clears the lock.
- ARB_OUT_LOCK_EN undefined: the in_last port and lock state are absent. Every beat is arbitrated independently and priority rotates on every transfer.

## Structure
- Shared package holds:
  - the log2 helper function used for out_src width;
  - localparam p_src_nbits = max(1, clog2(p_num_reqs)).
- One sub-module, arb_out_rr_core, contains:
  - the priority register (async active-low reset, one-hot bit 0 reset value);
  - the variable-priority replicated-chain grant logic.
  - It has an enable input (transfer, qualified by in_last when locking) and a lock override input.
- The top level holds the output register, can_accept/in_rdy logic, the one-hot-to-binary encoder for out_src, and the optional lock state.

## Test plan
- Reset, then N=4, all in_val=1, out_rdy=1 held → grants in order 0,1,2,3,0. Each out_msg appears 1 cycle after its in_rdy. out_src follows 0,1,2,3,0.
- Port 2 only requests with msg 0xA5A5A5A5 while out_rdy=0 → one transfer occurs, then in_rdy stays 0. out_val=1 and out_msg=0xA5A5A5A5 are held until out_rdy=1.
- Drain and refill in the same cycle: out_val=1, out_rdy=1, in_val[1]=1 → in_rdy[1]=1 and out_val stays 1 with the new message. No bubble.
- Ports 3 and 0 request with priority at bit 3 → port 3 is granted, next priority is bit 0 (wrap-around), and port 0 is granted next.
- Assert reset low while out_val=1 → out_val=0, out_src=0 and in_rdy=0 before the next clk edge. After release, port 0 has highest priority.
- Lock (ARB_OUT_LOCK_EN): port 1 sends 3 beats with in_last=0,0,1 while port 0 requests continuously → all three port-1 beats are consecutive, then port 2 priority applies and port 0 wins next.
